// File: rtl/ctrl_pipe_decode_if.sv
// Handshake and control-bundle bundle between the IF/ID register, the
// pipelined decoder and the execute stage.
interface ctrl_pipe_decode_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [2:0] cond;
    logic [2:0] flag_i;
    logic       flag_we_i;
    logic       stall_i;
    logic       flush_i;
    logic       out_valid;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       mem_en;
    logic       alu_src_imm;
    logic       lhb;
    logic       llb;
    logic       br_taken;
    logic       jal;
    logic       jr;
    logic       mem_wr_n;
    logic       exec_redirect;
    logic       exec_slot;
    logic       exec_return;
    logic       illegal;
    logic [2:0] flags_o;

    modport master (
        output in_valid, opcode, cond, flag_i, flag_we_i, stall_i, flush_i,
        input  in_ready, out_valid, alu_op, reg_we, mem_en, alu_src_imm, lhb, llb,
               br_taken, jal, jr, mem_wr_n, exec_redirect, exec_slot, exec_return,
               illegal, flags_o
    );

    modport slave (
        input  in_valid, opcode, cond, flag_i, flag_we_i, stall_i, flush_i,
        output in_ready, out_valid, alu_op, reg_we, mem_en, alu_src_imm, lhb, llb,
               br_taken, jal, jr, mem_wr_n, exec_redirect, exec_slot, exec_return,
               illegal, flags_o
    );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Registered control decoder for the 16-bit CPU: one-cycle decode with
// stall/flush, bypassable N/V/Z flag register and a one-shot EXEC sequencer.
module ctrl_pipe_decode #(
    parameter bit FLAG_BYPASS = 1'b1,
    parameter bit EXEC_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_pipe_decode_if.slave bus
);

    localparam logic [0:0] ST_RUN       = 1'b0;
    localparam logic [0:0] ST_EXEC_WAIT = 1'b1;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_we;
        logic       mem_en;
        logic       alu_src_imm;
        logic       lhb;
        logic       llb;
        logic       br_taken;
        logic       jal;
        logic       jr;
        logic       mem_wr_n;
        logic       exec_redirect;
        logic       exec_slot;
        logic       exec_return;
        logic       illegal;
    } bundle_t;

    function automatic bundle_t bundle_default();
        bundle_t b;
        b          = '0;
        b.alu_op   = 3'b000;
        b.mem_wr_n = 1'b1;
        return b;
    endfunction

    // flags are {N,V,Z}
    function automatic logic branch_sel(input logic [2:0] c, input logic [2:0] f);
        logic n;
        logic v;
        logic z;
        logic r;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'b000:  r = z;
            3'b001:  r = ~z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | (~z & ~n);
            3'b101:  r = z | n;
            3'b110:  r = v;
            3'b111:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bundle_t decode_base(input logic [3:0] op, input logic bs);
        bundle_t b;
        b = bundle_default();
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                b.alu_op = op[2:0];
                b.reg_we = 1'b1;
            end
            4'h4, 4'h5, 4'h6, 4'h7: begin
                b.alu_op      = op[2:0];
                b.reg_we      = 1'b1;
                b.alu_src_imm = 1'b1;
            end
            4'h8: begin
                b.reg_we      = 1'b1;
                b.mem_en      = 1'b1;
                b.alu_src_imm = 1'b1;
            end
            4'h9: begin
                b.mem_en      = 1'b1;
                b.mem_wr_n    = 1'b0;
                b.alu_src_imm = 1'b1;
            end
            4'hA: begin
                b.reg_we = 1'b1;
                b.lhb    = 1'b1;
            end
            4'hB: begin
                b.reg_we = 1'b1;
                b.llb    = 1'b1;
            end
            4'hC: b.br_taken = bs;
            4'hD: begin
                b.reg_we = 1'b1;
                b.jal    = 1'b1;
            end
            4'hE: b.jr            = 1'b1;
            4'hF: b.exec_redirect = 1'b1;
            default: b = bundle_default();
        endcase
        return b;
    endfunction

    logic [0:0] state_r;
    logic [0:0] state_nxt_s;
    logic [2:0] flags_r;
    logic [2:0] eff_flags_s;
    logic       accept_s;
    bundle_t    dec_s;
    bundle_t    bundle_r;
    logic       valid_r;

    assign bus.in_ready = rst_n & ~bus.stall_i;
    assign accept_s     = bus.in_valid & bus.in_ready;

    // Branch flag source selection and decode with EXEC sequencing overrides.
    always_comb begin
        eff_flags_s = flags_r;
        state_nxt_s = state_r;
        if (FLAG_BYPASS && bus.flag_we_i) begin
            eff_flags_s = bus.flag_i;
        end else begin
            eff_flags_s = flags_r;
        end
        dec_s = decode_base(bus.opcode, branch_sel(bus.cond, eff_flags_s));
        if (bus.opcode == 4'hF) begin
            if (!EXEC_EN) begin
                dec_s         = bundle_default();
                dec_s.illegal = 1'b1;
                state_nxt_s   = ST_RUN;
            end else if (state_r == ST_EXEC_WAIT) begin
                // nested EXEC: suppress it but still close the sequence
                dec_s             = bundle_default();
                dec_s.illegal     = 1'b1;
                dec_s.exec_return = 1'b1;
                state_nxt_s       = ST_RUN;
            end else begin
                state_nxt_s = ST_EXEC_WAIT;
            end
        end else if (state_r == ST_EXEC_WAIT) begin
            dec_s.exec_slot   = 1'b1;
            dec_s.exec_return = 1'b1;
            state_nxt_s       = ST_RUN;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Flag register, updated regardless of stall or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else if (bus.flag_we_i) begin
            flags_r <= bus.flag_i;
        end
    end

    // Output bundle register and EXEC sequencer state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r  <= 1'b0;
            bundle_r <= bundle_default();
            state_r  <= ST_RUN;
        end else if (bus.flush_i) begin
            valid_r  <= 1'b0;
            bundle_r <= bundle_default();
            state_r  <= ST_RUN;
        end else if (bus.stall_i) begin
            valid_r  <= valid_r;
            bundle_r <= bundle_r;
            state_r  <= state_r;
        end else if (accept_s) begin
            valid_r  <= 1'b1;
            bundle_r <= dec_s;
            state_r  <= state_nxt_s;
        end else begin
            valid_r  <= 1'b0;
            bundle_r <= bundle_default();
            state_r  <= state_r;
        end
    end

    assign bus.out_valid     = valid_r;
    assign bus.alu_op        = bundle_r.alu_op;
    assign bus.reg_we        = bundle_r.reg_we;
    assign bus.mem_en        = bundle_r.mem_en;
    assign bus.alu_src_imm   = bundle_r.alu_src_imm;
    assign bus.lhb           = bundle_r.lhb;
    assign bus.llb           = bundle_r.llb;
    assign bus.br_taken      = bundle_r.br_taken;
    assign bus.jal           = bundle_r.jal;
    assign bus.jr            = bundle_r.jr;
    assign bus.mem_wr_n      = bundle_r.mem_wr_n;
    assign bus.exec_redirect = bundle_r.exec_redirect;
    assign bus.exec_slot     = bundle_r.exec_slot;
    assign bus.exec_return   = bundle_r.exec_return;
    assign bus.illegal       = bundle_r.illegal;
    assign bus.flags_o       = flags_r;

endmodule

// File: tb/tb_ctrl_pipe_decode.sv
// Directed bench for ctrl_pipe_decode; instance a uses bypass and EXEC,
// instance b has FLAG_BYPASS=0 and EXEC_EN=0, both driven identically.
module tb_ctrl_pipe_decode;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    ctrl_pipe_decode_if bus_a ();
    ctrl_pipe_decode_if bus_b ();

    ctrl_pipe_decode #(.FLAG_BYPASS(1'b1), .EXEC_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ctrl_pipe_decode #(.FLAG_BYPASS(1'b0), .EXEC_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] c,
                         input logic fwe, input logic [2:0] fi,
                         input logic st, input logic fl);
        bus_a.in_valid = v;   bus_b.in_valid = v;
        bus_a.opcode = op;    bus_b.opcode = op;
        bus_a.cond = c;       bus_b.cond = c;
        bus_a.flag_we_i = fwe; bus_b.flag_we_i = fwe;
        bus_a.flag_i = fi;    bus_b.flag_i = fi;
        bus_a.stall_i = st;   bus_b.stall_i = st;
        bus_a.flush_i = fl;   bus_b.flush_i = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_a;
    logic [7:0] exp_b;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 4'h0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        step();
        check("rst_out_valid", {7'd0, bus_a.out_valid}, 8'd0);
        check("rst_mem_wr_n", {7'd0, bus_a.mem_wr_n}, 8'd1);
        check("rst_flags", {5'd0, bus_a.flags_o}, 8'd0);
        check("rst_in_ready", {7'd0, bus_a.in_ready}, 8'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_idle", {7'd0, bus_a.in_ready}, 8'd1);

        // ADD then idle
        drive(1'b1, 4'h0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("add_valid", {7'd0, bus_a.out_valid}, 8'd1);
        check("add_alu_op", {5'd0, bus_a.alu_op}, 8'd0);
        check("add_reg_we", {7'd0, bus_a.reg_we}, 8'd1);
        check("add_mem_wr_n", {7'd0, bus_a.mem_wr_n}, 8'd1);
        drive(1'b0, 4'h0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("idle_valid", {7'd0, bus_a.out_valid}, 8'd0);
        check("idle_reg_we", {7'd0, bus_a.reg_we}, 8'd0);

        // immediate ALU op 5
        drive(1'b1, 4'h5, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("imm_bundle", {bus_a.alu_op, bus_a.reg_we, bus_a.alu_src_imm, bus_a.mem_en}, {2'd0, 3'd5, 1'b1, 1'b1, 1'b0});

        // same-cycle flag write and branch on Z
        drive(1'b1, 4'hC, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0);
        step();
        check("bypass_a_br", {7'd0, bus_a.br_taken}, 8'd1);
        check("nobypass_b_br", {7'd0, bus_b.br_taken}, 8'd0);
        check("flags_after_we", {5'd0, bus_a.flags_o}, 8'd1);

        // all conditions with N=1,V=0,Z=0
        drive(1'b0, 4'h0, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0);
        step();
        exp_a = 8'b1010_1010;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'hC, c[2:0], 1'b0, 3'b000, 1'b0, 1'b0);
            step();
            check($sformatf("cond_n_%0d_a", c), {7'd0, bus_a.br_taken}, {7'd0, exp_a[c]});
            check($sformatf("cond_n_%0d_b", c), {7'd0, bus_b.br_taken}, {7'd0, exp_a[c]});
        end

        // all conditions with N=0,V=1,Z=0
        drive(1'b0, 4'h0, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0);
        step();
        exp_b = 8'b1101_0110;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 4'hC, c[2:0], 1'b0, 3'b000, 1'b0, 1'b0);
            step();
            check($sformatf("cond_v_%0d_a", c), {7'd0, bus_a.br_taken}, {7'd0, exp_b[c]});
        end

        // EXEC then LW then SUB
        drive(1'b1, 4'hF, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("exec_bundle_a", {bus_a.exec_redirect, bus_a.exec_slot, bus_a.illegal, bus_a.reg_we}, 8'b0000_1000);
        check("exec_dis_b", {bus_b.exec_redirect, bus_b.illegal, bus_b.out_valid}, 8'b0000_0011);
        drive(1'b1, 4'h8, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("lw_slot_a", {bus_a.exec_slot, bus_a.exec_return, bus_a.mem_en, bus_a.reg_we, bus_a.exec_redirect}, 8'b0001_1110);
        check("lw_slot_b", {bus_b.exec_slot, bus_b.exec_return, bus_b.mem_en}, 8'b0000_0001);
        drive(1'b1, 4'h1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("sub_after", {bus_a.exec_slot, bus_a.exec_return, bus_a.alu_op}, 8'b0000_0001);

        // nested EXEC
        drive(1'b1, 4'hF, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        step();
        check("nested_exec", {bus_a.illegal, bus_a.exec_return, bus_a.reg_we, bus_a.exec_redirect, bus_a.exec_slot}, 8'b0001_1000);
        drive(1'b1, 4'h0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("after_nested_run", {bus_a.exec_slot, bus_a.exec_return, bus_a.reg_we}, 8'b0000_0001);

        // SW then 3-cycle stall
        drive(1'b1, 4'h9, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("sw_bundle", {bus_a.out_valid, bus_a.mem_en, bus_a.mem_wr_n, bus_a.alu_src_imm}, 8'b0000_1101);
        drive(1'b1, 4'h0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0);
        #1;
        check("stall_in_ready", {7'd0, bus_a.in_ready}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold_%0d", i), {bus_a.out_valid, bus_a.mem_wr_n, bus_a.mem_en, bus_a.reg_we}, 8'b0000_1010);
        end
        drive(1'b0, 4'h0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("post_stall_idle", {7'd0, bus_a.out_valid}, 8'd0);

        // EXEC then flush with SUB presented
        drive(1'b1, 4'hF, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        drive(1'b1, 4'h1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1);
        step();
        check("flush_out", {bus_a.out_valid, bus_a.alu_op, bus_a.reg_we}, 8'd0);
        check("flush_flags", {5'd0, bus_a.flags_o}, 8'd2);
        drive(1'b1, 4'h8, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("post_flush_lw", {bus_a.exec_slot, bus_a.exec_return, bus_a.mem_en, bus_a.out_valid}, 8'b0000_0011);

        // mid-stream reset, taken while in EXEC_WAIT
        drive(1'b1, 4'hF, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        drive(1'b1, 4'h5, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("midrst_out", {bus_a.out_valid, bus_a.exec_redirect, bus_a.reg_we, bus_a.alu_op}, 8'd0);
        check("midrst_misc", {bus_a.mem_wr_n, bus_a.illegal, bus_a.flags_o}, 8'b0001_0000);
        rst_n = 1'b1;
        drive(1'b1, 4'h8, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0);
        step();
        check("postrst_no_slot", {bus_a.exec_slot, bus_a.exec_return, bus_a.mem_en}, 8'b0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_decode.md
# ctrl_pipe_decode

Registered, handshaked successor to the single-cycle control decoder for the 16-bit CPU datapath. Sits between the fetch/IF-ID register and the execute stage. Accepts one instruction per cycle, decodes opcode and branch condition against an internal, bypassable N/V/Z flag register, and issues a registered control bundle with one-cycle latency. Adds stall/flush support and a real EXEC sequencer: execute exactly one instruction at the EXEC target, then return.

## Interface
Parameters:
- FLAG_BYPASS, 1: 1 = branch evaluation uses flag_i when flag_we_i is high in the same cycle; 0 = always uses the stored flags.
- EXEC_EN, 1: 0 = EXEC opcode decodes as a NOP and pulses illegal.

Ports (reset is synchronous and active-low, one clock):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  combinational; = rst_n & !stall_i
- opcode  in  4  instruction[15:12]
- cond  in  3  branch condition field
- flag_i  in  3  {N,V,Z} from ALU
- flag_we_i  in  1  latch flag_i into flag register
- stall_i  in  1  hold outputs, block acceptance
- flush_i  in  1  kill pending output and EXEC sequence
- out_valid  out  1  control bundle valid
- alu_op  out  3  ALU operation
- reg_we, mem_en, alu_src_imm, lhb, llb, br_taken, jal, jr  out  1 each
- mem_wr_n  out  1  active-low memory write
- exec_redirect  out  1  fetch from EXEC target next
- exec_slot  out  1  bundle belongs to the EXEC target instruction
- exec_return  out  1  resume fetch at EXEC+1
- illegal  out  1  instruction suppressed
- flags_o  out  3  current flag register

## Operation
- Accept = in_valid & in_ready. An accepted instruction loads the output register at the next edge. No accept (and no stall) -> out_valid=0, all bundle bits at defaults.
- Defaults: alu_op=000, mem_wr_n=1, all other bundle bits 0.
- Decode:
  - 0–3: alu_op=opcode[2:0], reg_we.
  - 4–7: alu_op=opcode[2:0], reg_we, alu_src_imm.
  - 8 LW: reg_we, mem_en, alu_src_imm.
  - 9 SW: mem_en, mem_wr_n=0, alu_src_imm.
  - A LHB: reg_we, lhb.
  - B LLB: reg_we, llb.
  - C B: br_taken=BS.
  - D JAL: reg_we, jal.
  - E JR: jr.
  - F EXEC: exec_redirect.
- BS by cond: 000 Z; 001 !Z; 010 !Z&!N; 011 N; 100 Z|(!Z&!N); 101 Z|N; 110 V; 111 1.
- Flag register: loads flag_i on flag_we_i, independent of stall. Reset value 000.
- FSM states:
  - RUN: accepted EXEC -> EXEC_WAIT.
  - EXEC_WAIT: next accepted instruction issues with exec_slot=1 and exec_return=1 -> RUN.
  - Accepted EXEC in EXEC_WAIT: bundle forced to defaults, illegal=1, exec_return=1 -> RUN. Nested EXEC is forbidden.
  - exec_slot instruction B/JAL/JR: issues normally. Downstream gives the redirect priority over exec_return.
- EXEC_EN=0: opcode F issues defaults with illegal=1. FSM stays in RUN.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Reset (rst_n low at an edge): out_valid=0, bundle=defaults, exec_slot/exec_return/illegal=0, flags=000, FSM=RUN.
- stall_i high: output register and FSM hold; in_ready=0.
- flush_i (priority over stall and accept): next edge out_valid=0, bundle=defaults, FSM=RUN. The instruction presented that cycle is discarded, even if in_valid is high. flags are unaffected.
- exec_return, exec_redirect, illegal are valid only with out_valid. Under stall they are held, not re-pulsed.
- Simultaneous flag_we_i and a branch accept: BS uses flag_i if FLAG_BYPASS=1, otherwise the old flags.

## Test plan
- Reset, then ADD (0) with in_valid -> next cycle out_valid=1, alu_op=000, reg_we=1, mem_wr_n=1. Idle cycle after -> out_valid=0.
- flag_we_i with flag_i=001, same-cycle B cond=000 -> br_taken=1 (bypass). Repeat with FLAG_BYPASS=0 from flags 000 -> br_taken=0. Cover all 8 conds.
- EXEC, then LW -> EXEC bundle has exec_redirect=1. LW bundle has exec_slot=1, exec_return=1, mem_en=1, reg_we=1. Following SUB -> exec_slot=0.
- EXEC, EXEC -> second bundle has illegal=1, exec_return=1, reg_we=0. FSM back in RUN.
- SW accepted, then stall_i for 3 cycles -> in_ready=0; mem_wr_n=0 and out_valid=1 held constant all 3 cycles.
- EXEC, then flush_i with SUB presented -> out_valid=0. Next instruction issues with exec_slot=0. Mid-stream rst_n low -> all outputs at reset values one edge later.
